// File: rtl/sigdelay_pkg.sv
// Shared types and the saturating adder for the multi-channel delay/echo unit.
package sigdelay_pkg;

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        IDLE  = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MODE_BYPASS   = 2'd0,
        MODE_DELAY    = 2'd1,
        MODE_ECHO     = 2'd2,
        MODE_FEEDBACK = 2'd3
    } mode_t;

    // Adds two sign-extended samples and clamps to the signed range of a dw-bit word.
    // The caller keeps the low dw bits.
    function automatic int sat_add(input int x, input int s, input int dw);
        int sum;
        int hi;
        int lo;
        sum = x + s;
        hi  = (1 << (dw - 1)) - 1;
        lo  = -(1 << (dw - 1));
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/sigdelay_mc_if.sv
// Sample-vector handshake and output bus between the sample source and the delay unit.
interface sigdelay_mc_if #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8,
    parameter int N_CH    = 2
);
    logic                       in_valid;
    logic                       in_ready;
    logic [N_CH*D_WIDTH-1:0]    mic_signal;
    logic [N_CH*A_WIDTH-1:0]    offset;
    logic [1:0]                 mode;
    logic                       out_valid;
    logic [N_CH*D_WIDTH-1:0]    delayed_signal;
    logic [A_WIDTH-1:0]         current_address;

    modport master (
        output in_valid, mic_signal, offset, mode,
        input  in_ready, out_valid, delayed_signal, current_address
    );

    modport slave (
        input  in_valid, mic_signal, offset, mode,
        output in_ready, out_valid, delayed_signal, current_address
    );
endinterface

// File: rtl/delay_ram.sv
// Single-port synchronous RAM holding every channel's circular buffer; registered read.
module delay_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/sigdelay_mc.sv
// Multi-channel delay/echo: channels share one RAM, each owning a 2^A_WIDTH-word circular buffer
// addressed as {channel, pointer}; every accepted vector walks READ/WAIT/WRITE per channel.
module sigdelay_mc
    import sigdelay_pkg::*;
#(
    parameter int A_WIDTH  = 9,
    parameter int D_WIDTH  = 8,
    parameter int N_CH     = 2,
    parameter int FB_SHIFT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    sigdelay_mc_if.slave  bus
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CH_N   = 2 ** CH_W;
    localparam int RAM_AW = CH_W + A_WIDTH;
    localparam logic [RAM_AW-1:0] CLR_LAST = RAM_AW'(N_CH * (2 ** A_WIDTH) - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);

    state_t                     state_reg;
    mode_t                      mode_reg;
    logic [RAM_AW-1:0]          clr_cnt_reg;
    logic [CH_W-1:0]            ch_reg;
    logic [A_WIDTH-1:0]         ptr_reg;
    logic [N_CH*D_WIDTH-1:0]    x_reg;
    logic [N_CH*A_WIDTH-1:0]    off_reg;
    logic signed [D_WIDTH-1:0]  y_reg   [CH_N];
    logic signed [D_WIDTH-1:0]  out_reg [N_CH];
    logic                       out_valid_reg;

    logic signed [D_WIDTH-1:0]  x_ch   [CH_N];
    logic [A_WIDTH-1:0]         off_ch [CH_N];

    genvar gi;
    generate
        for (gi = 0; gi < CH_N; gi++) begin : g_ch
            if (gi < N_CH) begin : g_used
                assign x_ch[gi]   = x_reg[gi*D_WIDTH +: D_WIDTH];
                assign off_ch[gi] = off_reg[gi*A_WIDTH +: A_WIDTH];
                assign bus.delayed_signal[gi*D_WIDTH +: D_WIDTH] = out_reg[gi];
            end else begin : g_pad
                assign x_ch[gi]   = '0;
                assign off_ch[gi] = '0;
            end
        end
    endgenerate

    // Datapath for the channel currently being processed
    logic [D_WIDTH-1:0]         ram_rdata;
    logic signed [D_WIDTH-1:0]  x_cur;
    logic signed [D_WIDTH-1:0]  d_cur;
    logic signed [D_WIDTH-1:0]  s_cur;
    logic signed [D_WIDTH-1:0]  sat_cur;
    logic signed [D_WIDTH-1:0]  y_next;
    logic signed [D_WIDTH-1:0]  w_next;

    always_comb begin
        x_cur   = x_ch[ch_reg];
        d_cur   = signed'(ram_rdata);
        s_cur   = d_cur >>> FB_SHIFT;
        sat_cur = D_WIDTH'(sat_add(int'(x_cur), int'(s_cur), D_WIDTH));
        y_next  = x_cur;
        w_next  = x_cur;
        case (mode_reg)
            MODE_BYPASS:   begin y_next = x_cur;   w_next = x_cur;   end
            MODE_DELAY:    begin y_next = d_cur;   w_next = x_cur;   end
            MODE_ECHO:     begin y_next = sat_cur; w_next = x_cur;   end
            MODE_FEEDBACK: begin y_next = sat_cur; w_next = sat_cur; end
            default:       begin y_next = x_cur;   w_next = x_cur;   end
        endcase
    end

    // Reads and writes sit in different states, so one port serves both
    logic                 ram_we;
    logic                 ram_re;
    logic [RAM_AW-1:0]    ram_addr;
    logic [D_WIDTH-1:0]   ram_wdata;
    logic [A_WIDTH-1:0]   rd_ptr;

    always_comb begin
        rd_ptr    = ptr_reg - off_ch[ch_reg];
        ram_we    = en && ((state_reg == CLEAR) || (state_reg == WRITE));
        ram_re    = en && (state_reg == READ);
        ram_addr  = {ch_reg, ptr_reg};
        ram_wdata = w_next;
        if (state_reg == CLEAR) begin
            ram_addr  = clr_cnt_reg;
            ram_wdata = '0;
        end else if (state_reg == READ) begin
            ram_addr  = {ch_reg, rd_ptr};
        end
    end

    delay_ram #(
        .ADDR_WIDTH (RAM_AW),
        .DATA_WIDTH (D_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= CLEAR;
            mode_reg      <= MODE_BYPASS;
            clr_cnt_reg   <= '0;
            ch_reg        <= '0;
            ptr_reg       <= '0;
            x_reg         <= '0;
            off_reg       <= '0;
            out_valid_reg <= 1'b0;
            for (int i = 0; i < CH_N; i++) begin
                y_reg[i] <= '0;
            end
            for (int i = 0; i < N_CH; i++) begin
                out_reg[i] <= '0;
            end
        end else if (en) begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                CLEAR: begin
                    if (clr_cnt_reg == CLR_LAST) begin
                        clr_cnt_reg <= '0;
                        state_reg   <= IDLE;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + RAM_AW'(1);
                    end
                end
                IDLE: begin
                    if (bus.in_valid) begin
                        x_reg     <= bus.mic_signal;
                        off_reg   <= bus.offset;
                        mode_reg  <= mode_t'(bus.mode);
                        ch_reg    <= '0;
                        state_reg <= READ;
                    end
                end
                READ:  state_reg <= WAIT;
                WAIT:  state_reg <= WRITE;
                WRITE: begin
                    y_reg[ch_reg] <= y_next;
                    if (ch_reg == CH_LAST) begin
                        state_reg <= DONE;
                    end else begin
                        ch_reg    <= ch_reg + CH_W'(1);
                        state_reg <= READ;
                    end
                end
                DONE: begin
                    for (int i = 0; i < N_CH; i++) begin
                        out_reg[i] <= y_reg[i];
                    end
                    out_valid_reg <= 1'b1;
                    ptr_reg       <= ptr_reg + A_WIDTH'(1);
                    state_reg     <= IDLE;
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    // A strobe registered just before en drops stays pending and shows once en returns
    assign bus.in_ready        = en && (state_reg == IDLE);
    assign bus.out_valid       = en && out_valid_reg;
    assign bus.current_address = ptr_reg;

endmodule

// File: tb/tb_sigdelay_mc.sv
// Scoreboard bench for sigdelay_mc: a buffer model predicts each output vector at accept time.
module tb_sigdelay_mc;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NC = 2;

    logic clk;
    logic rst_n;
    logic en;

    sigdelay_mc_if #(.A_WIDTH(AW), .D_WIDTH(DW), .N_CH(NC)) bus ();

    sigdelay_mc #(
        .A_WIDTH  (AW),
        .D_WIDTH  (DW),
        .N_CH     (NC),
        .FB_SHIFT (1)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .en  (en),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model of the per-channel circular buffers
    logic signed [7:0] mdl_mem [NC][16];
    int                mdl_ptr;
    logic [15:0]       exp_q [$];
    int                addr_q [$];
    int                lat_q [$];
    int                acc_q [$];
    int                last_acc = 0;

    function automatic logic signed [7:0] sat8(input int v);
        if (v > 127)  return 8'sd127;
        if (v < -128) return -8'sd128;
        return 8'(v);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++)
            for (int a = 0; a < 16; a++)
                mdl_mem[c][a] = '0;
        mdl_ptr = 0;
        exp_q.delete();
        addr_q.delete();
        lat_q.delete();
        acc_q.delete();
    endtask

    task automatic model_push(input int x0, input int x1, input int o0, input int o1,
                              input int md, input int lat, input int acc);
        int                xs [NC];
        int                os [NC];
        logic signed [7:0] d, s, y, w, xv;
        logic [15:0]       yv;
        xs[0] = x0; xs[1] = x1; os[0] = o0; os[1] = o1;
        yv = '0;
        for (int c = 0; c < NC; c++) begin
            xv = 8'(xs[c]);
            d  = mdl_mem[c][(mdl_ptr - os[c]) & 15];
            s  = d >>> 1;
            case (md)
                0:       begin y = xv; w = xv; end
                1:       begin y = d;  w = xv; end
                2:       begin y = sat8(int'(xv) + int'(s)); w = xv; end
                default: begin y = sat8(int'(xv) + int'(s)); w = y;  end
            endcase
            mdl_mem[c][mdl_ptr] = w;
            yv[c*8 +: 8] = y;
        end
        mdl_ptr = (mdl_ptr + 1) % 16;
        exp_q.push_back(yv);
        addr_q.push_back(mdl_ptr);
        lat_q.push_back(lat);
        acc_q.push_back(acc);
    endtask

    // Output side: pop and compare on every strobe
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                logic [15:0] e;
                int a, l, ac;
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                l = lat_q.pop_front();
                ac = acc_q.pop_front();
                $display("[TB] out ch0=%0d ch1=%0d addr=%0d lat=%0d",
                         $signed(bus.delayed_signal[7:0]), $signed(bus.delayed_signal[15:8]),
                         bus.current_address, cyc - ac);
                check_eq("data", 32'(bus.delayed_signal), 32'(e));
                check_eq("addr", 32'(bus.current_address), 32'(a));
                check_eq("latency", 32'(cyc - ac), 32'(l));
            end
        end
    end

    task automatic do_reset();
        int cnt;
        int bad;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_addr", 32'(bus.current_address), 32'd0);
        check_eq("rst_data", 32'(bus.delayed_signal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        bad = 0;
        while (bus.in_ready !== 1'b1 && cnt < 100) begin
            if (bus.out_valid !== 1'b0 || bus.delayed_signal !== '0 || bus.current_address !== '0)
                bad++;
            cnt++;
            @(negedge clk);
        end
        check_eq("clear_len", 32'(cnt), 32'd32);
        check_eq("clear_outputs_quiet", 32'(bad), 32'd0);
    endtask

    task automatic send(input int x0, input int x1, input int o0, input int o1,
                        input int md, input int lat, input bit gap_chk);
        int n;
        int acc;
        bus.mic_signal = {8'(x1), 8'(x0)};
        bus.offset     = {4'(o1), 4'(o0)};
        bus.mode       = 2'(md);
        bus.in_valid   = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check_eq("accept_timeout", 32'(n), 32'd0);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (gap_chk) check_eq("accept_gap", 32'(acc - last_acc), 32'd8);
        last_acc = acc;
        model_push(x0, x1, o0, o1, md, lat, acc);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
            model_reset();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        en             = 1'b1;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.mic_signal = '0;
        bus.offset     = '0;
        bus.mode       = '0;

        // Power-up clear
        do_reset();

        // Pure delay, distinct offsets per channel
        for (int n = 0; n < 10; n++) send(n, -n, 3, 5, 1, 7, 1'b0);
        drain();

        // Back-to-back bypass: one accept every 8 cycles
        send($urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 0, 7, 1'b0);
        for (int n = 0; n < 6; n++)
            send($urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 0, 7, 1'b1);
        drain();

        // Echo with positive then negative saturation
        for (int n = 0; n < 5; n++) send(100, 100, 1, 1, 2, 7, 1'b0);
        for (int n = 0; n < 5; n++) send(-128, -128, 1, 1, 2, 7, 1'b0);
        drain();

        // Feedback impulse from a clean buffer
        do_reset();
        send(64, 0, 2, 2, 3, 7, 1'b0);
        for (int n = 0; n < 8; n++) send(0, 0, 2, 2, 3, 7, 1'b0);
        drain();

        // Offset 0 wraps the full buffer
        for (int n = 0; n < 18; n++) send(n, 3 * n, 0, 0, 1, 7, 1'b0);
        drain();

        // Enable stall of 5 cycles while waiting for RAM data
        send(-77, 55, 4, 9, 2, 12, 1'b0);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        en = 1'b1;
        drain();

        // Reset during a WRITE state aborts the vector and reruns the clear
        send(33, -33, 1, 1, 1, 7, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset();
        for (int n = 0; n < 3; n++) send(10 + n, 20 + n, 1, 2, 1, 7, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
